mb_io_master: RTL

Initiator side of the MicroBlaze MCS IO bus. It accepts single read/write requests from fabric logic over a valid/ready request channel. For each request it issues one IO bus transaction with strobes, waits for `IO_Ready` under a watchdog timeout, and returns read data or an error on a valid/ready response channel. It sits wherever non-processor logic, or a bench, must drive the team's IO-bus register slaves.

---
 rtl/mb_io_pkg.sv | 7 +
 rtl/mb_io_watchdog.sv | 18 +
 rtl/mb_io_master.sv | 83 ++++++++
 3 files changed

// File: rtl/mb_io_pkg.sv
// mb_io_pkg: shared types and constants for the MicroBlaze MCS IO bus master
package mb_io_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} mb_io_state_t;
  localparam int MB_IO_DATA_W = 32;
  localparam int MB_IO_BE_W = 4;
  localparam int MB_IO_TIMEOUT_DEF = 16;
endpackage

// File: rtl/mb_io_watchdog.sv
// mb_io_watchdog: clearable saturating 16-bit cycle counter flagging expiry at TIMEOUT
module mb_io_watchdog import mb_io_pkg::*; #(
  parameter int TIMEOUT = MB_IO_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam logic [15:0] LIM = 16'(TIMEOUT);
  logic [15:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable && cnt != 16'hffff) cnt <= cnt + 16'd1;
  assign expired = cnt >= LIM;
endmodule

// File: rtl/mb_io_master.sv
// mb_io_master: single-outstanding IO bus initiator with watchdog and valid/ready req/rsp channels
module mb_io_master import mb_io_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT = MB_IO_TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [MB_IO_BE_W-1:0]   req_be,
  input  logic [MB_IO_DATA_W-1:0] req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [MB_IO_DATA_W-1:0] rsp_rdata,
  output logic                    rsp_error,
  output logic                    stray_ready,
  output logic                    IO_Addr_Strobe,
  output logic                    IO_Read_Strobe,
  output logic                    IO_Write_Strobe,
  output logic [ADDR_WIDTH-1:0]   IO_Address,
  output logic [MB_IO_BE_W-1:0]   IO_Byte_Enable,
  output logic [MB_IO_DATA_W-1:0] IO_Write_Data,
  input  logic [MB_IO_DATA_W-1:0] IO_Read_Data,
  input  logic                    IO_Ready
);
  mb_io_state_t state, state_nxt;
  logic wr_q, expired;
  mb_io_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(clk),
    .reset(reset),
    .clear(state == ISSUE),
    .enable(state == WAIT),
    .expired(expired)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = req_valid ? ISSUE : IDLE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = (IO_Ready || expired) ? RESP : WAIT;
      RESP:    state_nxt = rsp_ready ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  // req_ready is gated by reset so it reads 0 while reset is held
  always_comb begin
    req_ready       = state == IDLE && !reset;
    rsp_valid       = state == RESP;
    IO_Addr_Strobe  = state == ISSUE;
    IO_Read_Strobe  = state == ISSUE && !wr_q;
    IO_Write_Strobe = state == ISSUE && wr_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q           <= 1'b0;
      IO_Address     <= '0;
      IO_Byte_Enable <= '0;
      IO_Write_Data  <= '0;
    end else if (state == IDLE && req_valid) begin
      wr_q           <= req_write;
      IO_Address     <= req_addr;
      IO_Byte_Enable <= req_be;
      IO_Write_Data  <= req_wdata;
    end
  // a ready coinciding with expiry completes normally
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      stray_ready <= 1'b0;
    end else begin
      stray_ready <= IO_Ready && (state == IDLE || state == RESP);
      if (state == WAIT && (IO_Ready || expired)) begin
        rsp_rdata <= (IO_Ready && !wr_q) ? IO_Read_Data : '0;
        rsp_error <= !IO_Ready;
      end
    end
endmodule
